// File: rtl/bimux_pkg.sv
// Shared encodings for the bit-mux sequencer.
package bimux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TURN = 2'd1,
    ST_XFER = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic OP_RD    = 1'b0;
  localparam logic OP_WR    = 1'b1;
  localparam logic DIR_NORM = 1'b0;
  localparam logic DIR_REV  = 1'b1;

endpackage

// File: rtl/bimux_bitcnt.sv
// Loadable up/down counter with an end-value flag; drives mux select and
// times the direction-turnaround gap.
module bimux_bitcnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  input  logic         i_en,
  input  logic         i_up,
  input  logic [W-1:0] i_end,
  output logic [W-1:0] o_cnt,
  output logic         o_last
);

  logic [W-1:0] r_cnt;

  // clear beats load beats step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_cnt <= '0;
    else if (i_clr)  r_cnt <= '0;
    else if (i_load) r_cnt <= i_val;
    else if (i_en)   r_cnt <= i_up ? r_cnt + 1'b1 : r_cnt - 1'b1;
  end

  assign o_cnt  = r_cnt;
  assign o_last = (r_cnt == i_end);

endmodule

// File: rtl/bimux_seq.sv
// Serialises one byte through a bidirectional 8x1 bit-mux, one bit per clock,
// with a turnaround gap whenever the mux direction flips.
module bimux_seq
  import bimux_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SEL_W     = 3,
  parameter int SETTLE    = 1,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rdata,
  output logic             mux_dir,
  output logic [SEL_W-1:0] mux_sel,
  input  logic             bit_in,
  output logic             bit_out,
  output logic             bit_oe
);

  localparam int ST_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam bit HAS_SETTLE = (SETTLE > 0);
  localparam logic [SEL_W-1:0] SEL_FIRST = MSB_FIRST ? SEL_W'(WIDTH-1) : '0;
  localparam logic [SEL_W-1:0] SEL_LAST  = MSB_FIRST ? '0 : SEL_W'(WIDTH-1);
  localparam logic [ST_W-1:0]  ST_LOAD   = HAS_SETTLE ? ST_W'(SETTLE-1) : '0;

  state_e           r_state, w_nxt;
  logic             r_wr, r_dir;
  logic [WIDTH-1:0] r_wdata, r_shadow, r_rdata, w_shadow_nxt;
  logic [SEL_W-1:0] w_sel;
  logic [ST_W-1:0]  w_st_cnt;
  logic             w_sel_last, w_st_last;
  logic             w_accept, w_turn, w_abort, w_xfer_end;

  assign w_accept   = (r_state == ST_IDLE) && req;
  assign w_turn     = w_accept && (wr != r_dir) && HAS_SETTLE;
  assign w_abort    = abort && ((r_state == ST_TURN) || (r_state == ST_XFER));
  assign w_xfer_end = (r_state == ST_XFER) && w_sel_last && !abort;

  // select sequencer: parked at 0 outside a transfer, first value from accept
  bimux_bitcnt #(.W(SEL_W)) u_selcnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_abort || ((r_state == ST_XFER) && w_sel_last)),
    .i_load (w_accept),
    .i_val  (SEL_FIRST),
    .i_en   (r_state == ST_XFER),
    .i_up   (!MSB_FIRST),
    .i_end  (SEL_LAST),
    .o_cnt  (w_sel),
    .o_last (w_sel_last)
  );

  // turnaround timer counts SETTLE-1 down to 0
  bimux_bitcnt #(.W(ST_W)) u_stcnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (1'b0),
    .i_load (w_turn),
    .i_val  (ST_LOAD),
    .i_en   (r_state == ST_TURN),
    .i_up   (1'b0),
    .i_end  ('0),
    .o_cnt  (w_st_cnt),
    .o_last (w_st_last)
  );

  // next-state decode; abort wins over a finishing turnaround or last bit
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE: if (req) w_nxt = w_turn ? ST_TURN : ST_XFER;
      ST_TURN: if (abort) w_nxt = ST_IDLE; else if (w_st_last) w_nxt = ST_XFER;
      ST_XFER: if (abort) w_nxt = ST_IDLE; else if (w_sel_last) w_nxt = ST_DONE;
      default: w_nxt = ST_IDLE;
    endcase
  end

  // shadow with the current bit merged, so the final bit reaches rdata on time
  always_comb begin
    w_shadow_nxt        = r_shadow;
    w_shadow_nxt[w_sel] = bit_in;
  end

  // state, latched op, direction and read capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_wr     <= OP_RD;
      r_wdata  <= '0;
      r_dir    <= DIR_NORM;
      r_shadow <= '0;
      r_rdata  <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_accept) begin
        r_wr    <= wr;
        r_wdata <= wdata;
        r_dir   <= wr;
      end
      if ((r_state == ST_XFER) && (r_wr == OP_RD)) r_shadow <= w_shadow_nxt;
      if (w_xfer_end && (r_wr == OP_RD))           r_rdata  <= w_shadow_nxt;
    end
  end

  assign busy    = (r_state != ST_IDLE);
  assign done    = (r_state == ST_DONE);
  assign rdata   = r_rdata;
  assign mux_dir = r_dir;
  assign mux_sel = w_sel;
  assign bit_oe  = (r_state == ST_XFER) && (r_wr == OP_WR);
  assign bit_out = bit_oe ? r_wdata[w_sel] : 1'b0;

endmodule

// File: tb/tb_bimux_seq.sv
// Directed bench for bimux_seq: scoreboard of expected completions checked by
// a monitor on done, plus in-line cycle checks from the stimulus thread.
module tb_bimux_seq;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       req, wr, abort;
  logic [7:0] wdata, mux_in;
  logic       busy, done, mux_dir, bit_in, bit_out, bit_oe;
  logic [7:0] rdata;
  logic [2:0] mux_sel;

  logic       req2, wr2, busy2, done2, mux_dir2, bit_in2, bit_out2, bit_oe2;
  logic [7:0] wdata2, rdata2, mux_in2;
  logic [2:0] mux_sel2;

  always #5 clk = ~clk;

  assign bit_in  = mux_in[mux_sel];
  assign bit_in2 = mux_in2[mux_sel2];

  bimux_seq #(.WIDTH(8), .SEL_W(3), .SETTLE(1), .MSB_FIRST(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wr(wr), .wdata(wdata), .abort(abort),
    .busy(busy), .done(done), .rdata(rdata), .mux_dir(mux_dir), .mux_sel(mux_sel),
    .bit_in(bit_in), .bit_out(bit_out), .bit_oe(bit_oe)
  );

  bimux_seq #(.WIDTH(8), .SEL_W(3), .SETTLE(1), .MSB_FIRST(1'b1)) u_dut_m (
    .clk(clk), .rst_n(rst_n), .req(req2), .wr(wr2), .wdata(wdata2), .abort(1'b0),
    .busy(busy2), .done(done2), .rdata(rdata2), .mux_dir(mux_dir2), .mux_sel(mux_sel2),
    .bit_in(bit_in2), .bit_out(bit_out2), .bit_oe(bit_oe2)
  );

  typedef struct {
    logic       wr;
    logic [7:0] rdata;
    logic [7:0] wbyte;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input logic w, input logic [7:0] rd, input logic [7:0] wb, input int lat);
    exp_t e;
    e = '{w, rd, wb, lat};
    sb.push_back(e);
  endtask

  // one-cycle req pulse; returns at the negedge of the first cycle after accept
  task automatic start(input logic w, input logic [7:0] d);
    @(negedge clk);
    wr = w; wdata = d; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_done(input int maxc, input string nm);
    for (int k = 0; k < maxc && !done; k++) @(negedge clk);
    chk(nm, done, 1'b1);
  endtask

  // monitor: tracks each transfer from busy rise and checks it on done
  initial begin
    int         b_start;
    int         oe_cnt;
    logic       busy_q;
    logic [7:0] wcap;
    exp_t       e;
    b_start = 0; oe_cnt = 0; busy_q = 1'b0; wcap = '0;
    forever begin
      @(negedge clk);
      if (busy && !busy_q) begin
        b_start = cyc;
        oe_cnt  = 0;
      end
      busy_q = busy;
      if (bit_oe) begin
        oe_cnt++;
        wcap[mux_sel] = bit_out;
        chk("oe_dir", mux_dir, 1'b1);
      end
      if (done) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk("mon_busy", busy, 1'b1);
          chk("mon_lat", cyc - b_start + 1, e.lat);
          chk("mon_oe_cycles", oe_cnt, e.wr ? 8 : 0);
          if (e.wr) chk("mon_wbyte", wcap, e.wbyte);
          chk("mon_rdata", rdata, e.rdata);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int         t1;
    logic [7:0] pat;
    req = 0; wr = 0; wdata = '0; abort = 0; mux_in = 8'hA5;
    req2 = 0; wr2 = 0; wdata2 = '0; mux_in2 = 8'h81;

    // reset values
    #1 rst_n = 1'b0;
    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_dir", mux_dir, 1'b0);
    chk("rst_sel", mux_sel, 3'd0);
    chk("rst_oe", bit_oe, 1'b0);
    chk("rst_out", bit_out, 1'b0);
    @(negedge clk) rst_n = 1'b1;

    // read A5, no turnaround
    push(1'b0, 8'hA5, 8'h00, 9);
    start(1'b0, 8'h00);
    for (int k = 0; k < 8; k++) begin
      chk("rd_sel", mux_sel, k);
      chk("rd_oe", bit_oe, 1'b0);
      @(negedge clk);
    end
    wait_done(3, "rd_done");

    // write 3C after read: one TURN cycle
    push(1'b1, 8'hA5, 8'h3C, 10);
    pat = 8'h3C;
    start(1'b1, 8'h3C);
    chk("turn_dir", mux_dir, 1'b1);
    chk("turn_oe", bit_oe, 1'b0);
    chk("turn_busy", busy, 1'b1);
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      chk("wr_sel", mux_sel, k);
      chk("wr_oe", bit_oe, 1'b1);
      chk("wr_bit", bit_out, pat[k]);
      @(negedge clk);
    end
    wait_done(3, "wr_done");

    // back-to-back writes of FF with req held
    push(1'b1, 8'hA5, 8'hFF, 9);
    push(1'b1, 8'hA5, 8'hFF, 9);
    @(negedge clk);
    wr = 1'b1; wdata = 8'hFF; req = 1'b1;
    wait_done(20, "b2b_done1");
    t1 = cyc;
    @(negedge clk);
    chk("b2b_gap_busy", busy, 1'b0);
    @(negedge clk);
    chk("b2b_second_busy", busy, 1'b1);
    req = 1'b0;
    wait_done(20, "b2b_done2");
    chk("b2b_spacing", cyc - t1, 10);

    // abort a read of 0F on XFER cycle 4 (turnaround first, dir was write)
    mux_in = 8'h0F;
    start(1'b0, 8'h00);
    repeat (4) @(negedge clk);
    chk("ab_sel", mux_sel, 3'd3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_busy", busy, 1'b0);
    chk("ab_oe", bit_oe, 1'b0);
    chk("ab_rdata", rdata, 8'hA5);
    chk("ab_dir", mux_dir, 1'b0);
    chk("ab_sel0", mux_sel, 3'd0);
    repeat (3) @(negedge clk);
    push(1'b0, 8'h0F, 8'h00, 9);
    start(1'b0, 8'h00);
    wait_done(12, "ab_reread_done");

    // async reset mid-XFER of a write
    start(1'b1, 8'h55);
    repeat (3) @(negedge clk);
    chk("pre_rst_oe", bit_oe, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_oe", bit_oe, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_dir", mux_dir, 1'b0);
    chk("arst_sel", mux_sel, 3'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("arst_idle", busy, 1'b0);

    // MSB-first instance: read 81
    @(negedge clk) req2 = 1'b1;
    @(negedge clk) req2 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("msb_sel", mux_sel2, 7 - k);
      @(negedge clk);
    end
    for (int k = 0; k < 3 && !done2; k++) @(negedge clk);
    chk("msb_done", done2, 1'b1);
    chk("msb_rdata", rdata2, 8'h81);

    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bimux_seq.md
Name: bimux_seq

Overview:
- Sequencer that owns one bidirectional 8x1 bit-mux in the subleq machine.
- Transfers one whole byte through the mux's single-bit line, one bit per clock.
- Read: collects mux input bits into `rdata`. Write: drives `wdata` bits back onto the mux inputs.
- Drives the mux's direction and select lines and enforces a turnaround gap whenever direction changes.
- Presents a simple req/done handshake to the datapath controller.

Parameters:
- WIDTH, 8, number of mux inputs / bits per transfer.
- SEL_W, 3, select width; must equal clog2(WIDTH).
- SETTLE, 1, idle cycles inserted when mux direction flips (0 = no gap).
- MSB_FIRST, 0, 0 = `sel` steps 0..WIDTH-1; 1 = `sel` steps WIDTH-1..0.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  1  start request; sampled only in IDLE.
- wr  in  1  op: 0 = read mux inputs to `rdata`, 1 = write `wdata` to mux inputs.
- wdata  in  WIDTH  write byte; latched at accept.
- abort  in  1  synchronous cancel of an in-flight transfer.
- busy  out  1  high from the cycle after accept through the DONE cycle.
- done  out  1  one-cycle completion pulse.
- rdata  out  WIDTH  last completed read byte.
- mux_dir  out  1  to mux `dir` (0 normal/read, 1 reverse/write).
- mux_sel  out  SEL_W  to mux `sel`.
- bit_in  in  1  mux single-bit line as seen during read.
- bit_out  out  1  value driven on the mux single-bit line during write.
- bit_oe  out  1  tri-state enable for `bit_out`.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset values: state=IDLE, busy=0, done=0, rdata=0, mux_dir=0, mux_sel=0, bit_out=0, bit_oe=0, count=0.
- Reset asserted mid-transfer aborts immediately with no `done`.
- States: IDLE, TURN, XFER, DONE.
- IDLE:
  - `req`=1 at an edge accepts the request and latches `wr` and `wdata`.
  - If latched `wr` != current `mux_dir` and SETTLE>0: `mux_dir`<=wr, go to TURN.
  - Otherwise `mux_dir`<=wr, go to XFER.
- TURN:
  - `bit_oe`=0; `mux_sel` holds the first select value.
  - Lasts exactly SETTLE cycles, then goes to XFER.
- XFER:
  - Lasts exactly WIDTH cycles. In cycle k, `mux_sel` = k (or WIDTH-1-k when MSB_FIRST=1).
  - Read: `bit_in` is sampled at the end of cycle k into shadow[`mux_sel`]; `bit_oe`=0.
  - Write: `bit_out`=wdata_l[`mux_sel`] and `bit_oe`=1 for the whole cycle.
  - After the last bit, go to DONE.
- DONE:
  - `done`=1 and `busy`=1 for one cycle; `bit_oe`=0.
  - On a read, `rdata`<=shadow at entry to DONE, so `rdata` is valid while `done`=1. A write leaves `rdata` unchanged.
  - Then return to IDLE.
- Latency (accept edge = E0, no turnaround): XFER occupies cycles 1..WIDTH, DONE is cycle WIDTH+1. A turnaround adds SETTLE cycles.
- `mux_dir` persists between transfers. Turnaround cost is paid only on a direction change.
- `req` during busy is ignored and not queued. `req` held high through DONE is accepted in the following IDLE cycle, so back-to-back transfers have 1 IDLE cycle between DONE and the next accept.
- abort=1 in TURN or XFER:
  - Next state IDLE; no `done`; `bit_oe`=0 next cycle.
  - `rdata` unchanged; `mux_dir` keeps its new value.
  - abort in IDLE or DONE has no effect (a DONE cycle still completes).
- `mux_sel` is 0 in IDLE.
- `bit_oe` is never 1 in the same cycle in which `mux_dir` changes.

Decomposition:
- Shared package `bimux_pkg` holds:
  - state encoding enum (IDLE=0, TURN=1, XFER=2, DONE=3);
  - op constants OP_RD=0, OP_WR=1;
  - direction constants DIR_NORM=0, DIR_REV=1.
- One natural sub-module, `bimux_bitcnt`: loadable up/down bit counter producing `mux_sel` and a last-bit flag. It is also used for the SETTLE countdown.

Test Plan:
- Reset then read: mux inputs = 8'hA5, wr=0, req pulse.
  - `mux_sel` steps 0..7 in cycles 1..8; `done`=1 in cycle 9; `rdata`=8'hA5; `bit_oe` stays 0; no TURN.
- Write after read: wr=1, wdata=8'h3C, SETTLE=1.
  - One TURN cycle with `mux_dir`=1 and `bit_oe`=0.
  - Then 8 cycles with `bit_out`=0,0,1,1,1,1,0,0 at `sel` 0..7 and `bit_oe`=1.
  - `done` arrives 10 cycles after accept; `rdata` still 8'hA5.
- Back-to-back writes: two writes of 8'hFF with `req` held high.
  - No TURN on the second; one IDLE cycle between first `done` and second accept; second `done` 10 cycles after the first.
- Abort: assert abort on XFER cycle 4 of a read of 8'h0F.
  - IDLE next cycle, no `done`, `rdata` unchanged.
  - A subsequent read returns 8'h0F correctly.
- Async reset mid-transfer: drop `rst_n` mid-XFER of a write.
  - `bit_oe`, `busy`, `mux_dir` and `mux_sel` go to 0 without waiting for a clock edge; no `done` after release.
- MSB_FIRST=1 read of 8'h81.
  - `mux_sel` sequence 7..0; `rdata`=8'h81.
